// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I front end: NOP encoding, reset PC,
// fetch state encoding and a PC alignment helper.
package rv32i_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // Force a redirect target onto a word boundary; the low two bits are dropped.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv32i_fetch_skid.sv
// One-entry {pc, inst} buffer that catches an instruction accepted from
// memory while decode is stalled. Clear beats load, load beats drain.
module rv32i_fetch_skid
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        full_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        full_q, full_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Next-state for occupancy and payload.
  always_comb begin
    full_d = full_q;
    pc_d   = pc_q;
    inst_d = inst_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      pc_d   = pc_i;
      inst_d = inst_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Buffer registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      pc_q   <= 32'h0000_0000;
      inst_q <= NOP_INST;
    end else begin
      full_q <= full_d;
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/rv32i_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives a single-port
// instruction memory with a same-cycle req/ack handshake, and presents
// registered {pc, inst, valid} to decode. A one-entry skid buffer absorbs
// a decode stall that arrives together with a memory transfer.
module rv32i_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] o_iaddr,
  output logic        o_ireq,
  input  logic        i_iack,
  input  logic [31:0] i_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_next_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  iaddr_q, iaddr_d;
  logic         ireq_q,  ireq_d;
  logic [31:0]  pc_q,    pc_d;
  logic [31:0]  inst_q,  inst_d;
  logic         valid_q, valid_d;

  logic         transfer_s;
  logic         skid_load_s;
  logic         skid_drain_s;
  logic         skid_clear_s;
  logic         skid_full_s;
  logic [31:0]  skid_pc_s;
  logic [31:0]  skid_inst_s;

  assign transfer_s = ireq_q & i_iack;

  rv32i_fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load_s),
    .drain_i (skid_drain_s),
    .clear_i (skid_clear_s),
    .pc_i    (iaddr_q),
    .inst_i  (i_inst),
    .full_o  (skid_full_s),
    .pc_o    (skid_pc_s),
    .inst_o  (skid_inst_s)
  );

  // Next-state and datapath control; flush overrides every state.
  always_comb begin
    state_d      = state_q;
    iaddr_d      = iaddr_q;
    ireq_d       = ireq_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    skid_load_s  = 1'b0;
    skid_drain_s = 1'b0;
    skid_clear_s = 1'b0;

    if (i_flush) begin
      // Any same-cycle transfer is dropped: iaddr/pc are not advanced from it.
      skid_clear_s = 1'b1;
      state_d      = FETCH_REQ;
      ireq_d       = 1'b1;
      iaddr_d      = pc_align(i_next_pc);
      valid_d      = 1'b0;
      inst_d       = NOP_INST;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          state_d = FETCH_REQ;
          ireq_d  = 1'b1;
          iaddr_d = PC_RESET;
        end
        FETCH_REQ: begin
          if (transfer_s) begin
            if (i_stall) begin
              // Decode is busy: park the word and stop requesting.
              skid_load_s = 1'b1;
              iaddr_d     = iaddr_q + PC_STEP;
              ireq_d      = 1'b0;
              state_d     = FETCH_HOLD;
            end else begin
              pc_d    = iaddr_q;
              inst_d  = i_inst;
              valid_d = 1'b1;
              iaddr_d = iaddr_q + PC_STEP;
            end
          end else if (!i_stall) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
          end else begin
            valid_d = valid_q;
          end
        end
        FETCH_HOLD: begin
          if (!skid_full_s) begin
            // Nothing buffered (cannot normally happen): resume fetching.
            state_d = FETCH_REQ;
            ireq_d  = 1'b1;
          end else if (!i_stall) begin
            pc_d         = skid_pc_s;
            inst_d       = skid_inst_s;
            valid_d      = 1'b1;
            skid_drain_s = 1'b1;
            ireq_d       = 1'b1;
            state_d      = FETCH_REQ;
          end else begin
            state_d = FETCH_HOLD;
          end
        end
        default: begin
          state_d = FETCH_IDLE;
          ireq_d  = 1'b0;
        end
      endcase
    end
  end

  // Stage registers with asynchronous reset to the idle, empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      iaddr_q <= PC_RESET;
      ireq_q  <= 1'b0;
      pc_q    <= 32'h0000_0000;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iaddr_q <= iaddr_d;
      ireq_q  <= ireq_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign o_iaddr = iaddr_q;
  assign o_ireq  = ireq_q;
  assign o_pc    = pc_q;
  assign o_inst  = inst_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: directed scenarios with literal
// expectations, then randomized stall/ack/flush traffic compared every
// cycle against a behavioural model, then an asynchronous mid-run reset.
module tb_rv32i_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] o_iaddr;
  logic        o_ireq;
  logic        i_iack;
  logic [31:0] i_inst;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_valid;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_next_pc;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: started flag, fetch address, decode-side outputs,
  // and a queue of instructions accepted but not yet handed to decode.
  bit          m_started;
  logic [31:0] m_iaddr;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_valid;
  logic [63:0] m_pending[$];

  rv32i_fetch #(.PC_RESET(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_iaddr   (o_iaddr),
    .o_ireq    (o_ireq),
    .i_iack    (i_iack),
    .i_inst    (i_inst),
    .o_pc      (o_pc),
    .o_inst    (o_inst),
    .o_valid   (o_valid),
    .i_stall   (i_stall),
    .i_flush   (i_flush),
    .i_next_pc (i_next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents derived from the address so each word is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0017;
  endfunction

  assign i_inst = mem_word(o_iaddr);

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_req();
    return m_started && (m_pending.size() == 0);
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_iaddr   = 32'h0000_0000;
    m_pc      = 32'h0000_0000;
    m_inst    = NOP;
    m_valid   = 1'b0;
    m_pending.delete();
  endtask

  // Apply one clock of the fetch rules to the model using the current inputs.
  task automatic model_clock();
    logic [63:0] e;
    if (i_flush) begin
      m_valid   = 1'b0;
      m_inst    = NOP;
      m_pending.delete();
      m_iaddr   = i_next_pc & 32'hFFFF_FFFC;
      m_started = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_pending.size() != 0) begin
      if (!i_stall) begin
        e       = m_pending.pop_front();
        m_pc    = e[63:32];
        m_inst  = e[31:0];
        m_valid = 1'b1;
      end
    end else if (i_iack) begin
      if (i_stall) begin
        m_pending.push_back({m_iaddr, mem_word(m_iaddr)});
      end else begin
        m_pc    = m_iaddr;
        m_inst  = mem_word(m_iaddr);
        m_valid = 1'b1;
      end
      m_iaddr = m_iaddr + 32'd4;
    end else if (!i_stall) begin
      m_valid = 1'b0;
      m_inst  = NOP;
    end
  endtask

  task automatic compare_all();
    cmp("iaddr", o_iaddr, m_iaddr);
    cmp("ireq",  {31'd0, o_ireq}, {31'd0, m_req()});
    cmp("valid", {31'd0, o_valid}, {31'd0, m_valid});
    cmp("inst",  o_inst, m_inst);
    if (m_valid) cmp("pc", o_pc, m_pc);
  endtask

  // One cycle: drive inputs, clock DUT and model, then compare off-edge.
  task automatic step(input bit stall, input bit ack, input bit flush, input logic [31:0] nxt);
    i_stall   = stall;
    i_iack    = ack;
    i_flush   = flush;
    i_next_pc = nxt;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_iaddr"}, o_iaddr, 32'h0000_0000);
    cmp({tag, "_ireq"},  {31'd0, o_ireq}, 32'd0);
    cmp({tag, "_pc"},    o_pc, 32'h0000_0000);
    cmp({tag, "_inst"},  o_inst, 32'h0000_0013);
    cmp({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_stall   = 1'b0;
    i_iack    = 1'b0;
    i_flush   = 1'b0;
    i_next_pc = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Startup: IDLE then back-to-back fetch.
    step(0, 1, 0, 32'h0);
    cmp("start_ireq",  {31'd0, o_ireq}, 32'd1);
    cmp("start_valid", {31'd0, o_valid}, 32'd0);
    step(0, 1, 0, 32'h0);
    cmp("first_pc",    o_pc, 32'h0000_0000);
    cmp("first_valid", {31'd0, o_valid}, 32'd1);
    cmp("first_inst",  o_inst, 32'hC0DE_0017);
    cmp("first_iaddr", o_iaddr, 32'h0000_0004);
    step(0, 1, 0, 32'h0);
    cmp("second_pc", o_pc, 32'h0000_0004);

    // Two cycles without ack at 0x8.
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    cmp("noack_iaddr", o_iaddr, 32'h0000_0008);
    cmp("noack_valid", {31'd0, o_valid}, 32'd0);
    cmp("noack_inst",  o_inst, 32'h0000_0013);
    step(0, 1, 0, 32'h0);
    cmp("after_noack_pc", o_pc, 32'h0000_0008);
    step(0, 1, 0, 32'h0);
    cmp("pc_0c", o_pc, 32'h0000_000C);

    // Stall arrives with the transfer of 0x10, held 3 cycles.
    step(1, 1, 0, 32'h0);
    cmp("stall_ireq", {31'd0, o_ireq}, 32'd0);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    cmp("stall_pc_hold", o_pc, 32'h0000_000C);
    step(0, 1, 0, 32'h0);
    cmp("skid_pc", o_pc, 32'h0000_0010);
    cmp("skid_inst", o_inst, mem_word(32'h0000_0010));
    step(0, 1, 0, 32'h0);
    cmp("post_skid_pc", o_pc, 32'h0000_0014);
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    cmp("pre_flush_iaddr", o_iaddr, 32'h0000_0020);

    // Flush colliding with a transfer at 0x20.
    step(0, 1, 1, 32'h0000_0200);
    cmp("flush_valid", {31'd0, o_valid}, 32'd0);
    cmp("flush_iaddr", o_iaddr, 32'h0000_0200);
    step(0, 1, 0, 32'h0);
    cmp("flush_target_pc", o_pc, 32'h0000_0200);

    // Flush while holding a skid entry under stall.
    step(1, 1, 0, 32'h0);
    step(1, 0, 1, 32'h0000_0103);
    cmp("hold_flush_iaddr", o_iaddr, 32'h0000_0100);
    cmp("hold_flush_valid", {31'd0, o_valid}, 32'd0);
    cmp("hold_flush_ireq",  {31'd0, o_ireq}, 32'd1);
    step(0, 1, 0, 32'h0);
    cmp("hold_flush_pc", o_pc, 32'h0000_0100);

    // Address wrap.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 32'h0);
    cmp("wrap_pc",    o_pc, 32'hFFFF_FFFC);
    cmp("wrap_iaddr", o_iaddr, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 24) == 0, $urandom);
    end

    // Asynchronous reset mid-stream, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    check_reset_values("rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step(($urandom % 3) == 0, ($urandom % 2) != 0, ($urandom % 32) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
